alarm_controller: RTL and testbench

//  Downstream consumer of the digital clock's BCD time digits. Holds a user-set

---
 rtl/alarm_controller_if.sv | 36 +++
 rtl/alarm_controller.sv | 166 ++++++++++++++++
 tb/tb_alarm_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_controller_if.sv
// Signal bundle between the digital clock / user controls and the alarm controller.
// The slave modport is the alarm controller's view; master is the driver's view.
interface alarm_controller_if;
    logic       alarm_en;
    logic       set_alarm;
    logic [3:0] adj_HT;
    logic [3:0] adj_HU;
    logic [3:0] adj_MT;
    logic [3:0] adj_MU;
    logic [3:0] HourTens;
    logic [3:0] HourUnits;
    logic [3:0] minTens;
    logic [3:0] minUnits;
    logic [3:0] secTens;
    logic [3:0] secUnits;
    logic       snooze;
    logic       stop;
    logic       buzzer;
    logic       ringing;
    logic       alarm_led;
    logic       set_err;

    modport slave (
        input  alarm_en, set_alarm, adj_HT, adj_HU, adj_MT, adj_MU,
        input  HourTens, HourUnits, minTens, minUnits, secTens, secUnits,
        input  snooze, stop,
        output buzzer, ringing, alarm_led, set_err
    );

    modport master (
        output alarm_en, set_alarm, adj_HT, adj_HU, adj_MT, adj_MU,
        output HourTens, HourUnits, minTens, minUnits, secTens, secUnits,
        output snooze, stop,
        input  buzzer, ringing, alarm_led, set_err
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: holds an HH:MM alarm, matches it against live BCD time and
// runs an IDLE / RINGING / SNOOZE state machine driving a beeping buzzer and LED.
module alarm_controller #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned RING_SECS     = 60,
    parameter int unsigned SNOOZE_SECS   = 300
) (
    input  logic         clk,
    input  logic         rst,
    alarm_controller_if.slave bus
);
    localparam int unsigned BW = $clog2(TICKS_PER_SEC) + 1;
    localparam int unsigned RW = $clog2(RING_SECS) + 1;
    localparam int unsigned SW = $clog2(SNOOZE_SECS) + 1;

    localparam logic [BW-1:0] BEEP_LAST = BW'(TICKS_PER_SEC / 2 - 1);
    localparam logic [RW-1:0] RING_END  = RW'(RING_SECS);
    localparam logic [SW-1:0] SNZ_INIT  = SW'(SNOOZE_SECS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          buzzer_q, buzzer_d;

    logic [3:0]    al_ht, al_hu, al_mt, al_mu;
    logic          set_err_q;
    logic [3:0]    sec_q;
    logic          snooze_q, stop_q;

    logic          adj_valid;
    logic          sec_stb;
    logic          snooze_edge, stop_edge;
    logic          match;

    always_comb begin
        adj_valid = (bus.adj_HT <= 4'd2) && (bus.adj_HU <= 4'd9) &&
                    !((bus.adj_HT == 4'd2) && (bus.adj_HU > 4'd3)) &&
                    (bus.adj_MT <= 4'd5) && (bus.adj_MU <= 4'd9);
    end

    assign sec_stb     = (bus.secUnits != sec_q);
    assign snooze_edge = bus.snooze & ~snooze_q;
    assign stop_edge   = bus.stop & ~stop_q;

    assign match = sec_stb && bus.alarm_en && !bus.set_alarm &&
                   (bus.secTens == 4'd0) && (bus.secUnits == 4'd0) &&
                   (bus.HourTens == al_ht) && (bus.HourUnits == al_hu) &&
                   (bus.minTens == al_mt) && (bus.minUnits == al_mu);

    // sec_q reloads the live seconds digit on reset so no spurious strobe follows it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_ht     <= '0;
            al_hu     <= '0;
            al_mt     <= '0;
            al_mu     <= '0;
            set_err_q <= 1'b0;
            sec_q     <= bus.secUnits;
            snooze_q  <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            set_err_q <= bus.set_alarm & ~adj_valid;
            if (bus.set_alarm && adj_valid) begin
                al_ht <= bus.adj_HT;
                al_hu <= bus.adj_HU;
                al_mt <= bus.adj_MT;
                al_mu <= bus.adj_MU;
            end
            sec_q    <= bus.secUnits;
            snooze_q <= bus.snooze;
            stop_q   <= bus.stop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            beep_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    // Priority inside each state: alarm_en=0 > stop > snooze > timeout/expiry > match
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        beep_cnt_d = '0;
        buzzer_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ring_cnt_d = '0;
                snz_cnt_d  = '0;
                if (match) begin
                    state_d  = RINGING;
                    buzzer_d = 1'b1;
                end
            end
            RINGING: begin
                if (!bus.alarm_en || stop_edge) begin
                    state_d    = IDLE;
                    ring_cnt_d = '0;
                end else if (snooze_edge) begin
                    state_d    = SNOOZE;
                    snz_cnt_d  = SNZ_INIT;
                    ring_cnt_d = '0;
                end else if (sec_stb && (ring_cnt_q + RW'(1) == RING_END)) begin
                    state_d    = IDLE;
                    ring_cnt_d = '0;
                end else begin
                    if (sec_stb) begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                    end
                    if (beep_cnt_q == BEEP_LAST) begin
                        beep_cnt_d = '0;
                        buzzer_d   = ~buzzer_q;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BW'(1);
                        buzzer_d   = buzzer_q;
                    end
                end
            end
            SNOOZE: begin
                if (!bus.alarm_en || stop_edge) begin
                    state_d   = IDLE;
                    snz_cnt_d = '0;
                end else if (sec_stb) begin
                    if (snz_cnt_q <= SW'(1)) begin
                        state_d    = RINGING;
                        snz_cnt_d  = '0;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SW'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                ring_cnt_d = '0;
                snz_cnt_d  = '0;
            end
        endcase
    end

    assign bus.buzzer    = buzzer_q;
    assign bus.ringing   = (state_q == RINGING);
    assign bus.alarm_led = (state_q == RINGING) || (state_q == SNOOZE);
    assign bus.set_err   = set_err_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller at TICKS_PER_SEC=4, RING_SECS=5, SNOOZE_SECS=3.
// Expected {buzzer, ringing, alarm_led, set_err} are queued per driven cycle and checked after the edge.
module tb_alarm_controller;
    logic clk = 1'b0;
    logic rst;

    alarm_controller_if bus ();

    alarm_controller #(
        .TICKS_PER_SEC(4),
        .RING_SECS    (5),
        .SNOOZE_SECS  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic        set;
        logic [15:0] adj;
        logic [23:0] tm;
        logic        snz;
        logic        stp;
        logic [3:0]  exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input string n, input logic en, input logic set,
                                input logic [15:0] adj, input logic [23:0] tm,
                                input logic snz, input logic stp, input logic [3:0] e);
        vec_t v;
        v.name = n; v.en = en; v.set = set; v.adj = adj; v.tm = tm;
        v.snz = snz; v.stp = stp; v.exp = e;
        return v;
    endfunction

    task automatic drive_tm(input logic [23:0] t);
        bus.HourTens  = t[23:20];
        bus.HourUnits = t[19:16];
        bus.minTens   = t[15:12];
        bus.minUnits  = t[11:8];
        bus.secTens   = t[7:4];
        bus.secUnits  = t[3:0];
    endtask

    task automatic drive_adj(input logic [15:0] a);
        bus.adj_HT = a[15:12];
        bus.adj_HU = a[11:8];
        bus.adj_MT = a[7:4];
        bus.adj_MU = a[3:0];
    endtask

    task automatic push_exp(input string nm, input logic [3:0] e);
        exp_t x;
        x.name = nm;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic check_out();
        exp_t       x;
        logic [3:0] got;
        got = {bus.buzzer, bus.ringing, bus.alarm_led, bus.set_err};
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %b with no expectation queued", got);
        end else begin
            x = sbq.pop_front();
            if (got !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got {buz,ring,led,err}=%b expected %b", x.name, got, x.exp);
            end
        end
    endtask

    task automatic tick(input string nm, input logic [3:0] e);
        push_exp(nm, e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic step(input string nm, input logic [23:0] tm, input logic snz,
                        input logic stp, input logic [3:0] e);
        drive_tm(tm);
        bus.snooze = snz;
        bus.stop   = stp;
        tick(nm, e);
    endtask

    vec_t tbl[20];

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk("load_0730",  1'b1, 1'b1, 16'h0730, 24'h072958, 1'b0, 1'b0, 4'b0000);
        tbl[1]  = mk("pre_match",  1'b1, 1'b0, 16'h0730, 24'h072959, 1'b0, 1'b0, 4'b0000);
        tbl[2]  = mk("match",      1'b1, 1'b0, 16'h0730, 24'h073000, 1'b0, 1'b0, 4'b1110);
        tbl[3]  = mk("beep_a",     1'b1, 1'b0, 16'h0730, 24'h073000, 1'b0, 1'b0, 4'b1110);
        tbl[4]  = mk("beep_b",     1'b1, 1'b0, 16'h0730, 24'h073000, 1'b0, 1'b0, 4'b0110);
        tbl[5]  = mk("beep_c",     1'b1, 1'b0, 16'h0730, 24'h073000, 1'b0, 1'b0, 4'b0110);
        tbl[6]  = mk("beep_d",     1'b1, 1'b0, 16'h0730, 24'h073000, 1'b0, 1'b0, 4'b1110);
        tbl[7]  = mk("ring_s1",    1'b1, 1'b0, 16'h0730, 24'h073001, 1'b0, 1'b0, 4'b1110);
        tbl[8]  = mk("ring_s2",    1'b1, 1'b0, 16'h0730, 24'h073002, 1'b0, 1'b0, 4'b0110);
        tbl[9]  = mk("ring_s3",    1'b1, 1'b0, 16'h0730, 24'h073003, 1'b0, 1'b0, 4'b0110);
        tbl[10] = mk("ring_s4",    1'b1, 1'b0, 16'h0730, 24'h073004, 1'b0, 1'b0, 4'b1110);
        tbl[11] = mk("timeout",    1'b1, 1'b0, 16'h0730, 24'h073005, 1'b0, 1'b0, 4'b0000);
        tbl[12] = mk("idle_hold",  1'b1, 1'b0, 16'h0730, 24'h073005, 1'b0, 1'b0, 4'b0000);
        tbl[13] = mk("bad_2400",   1'b1, 1'b1, 16'h2400, 24'h073005, 1'b0, 1'b0, 4'b0001);
        tbl[14] = mk("bad_1960",   1'b1, 1'b1, 16'h1960, 24'h073005, 1'b0, 1'b0, 4'b0001);
        tbl[15] = mk("set_off",    1'b1, 1'b0, 16'h1960, 24'h073005, 1'b0, 1'b0, 4'b0000);
        tbl[16] = mk("keep_pre",   1'b1, 1'b0, 16'h1960, 24'h072959, 1'b0, 1'b0, 4'b0000);
        tbl[17] = mk("keep_match", 1'b1, 1'b0, 16'h1960, 24'h073000, 1'b0, 1'b0, 4'b1110);
        tbl[18] = mk("stop",       1'b1, 1'b0, 16'h1960, 24'h073000, 1'b0, 1'b1, 4'b0000);
        tbl[19] = mk("stop_rel",   1'b1, 1'b0, 16'h1960, 24'h073000, 1'b0, 1'b0, 4'b0000);

        rst           = 1'b1;
        bus.alarm_en  = 1'b1;
        bus.set_alarm = 1'b0;
        bus.snooze    = 1'b0;
        bus.stop      = 1'b0;
        drive_adj(16'h0000);
        drive_tm(24'h072958);
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 4'b0000);
        check_out();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.alarm_en  = tbl[i].en;
            bus.set_alarm = tbl[i].set;
            drive_adj(tbl[i].adj);
            drive_tm(tbl[i].tm);
            bus.snooze = tbl[i].snz;
            bus.stop   = tbl[i].stp;
            tick(tbl[i].name, tbl[i].exp);
        end

        // snooze, three strobes back to ringing, then stop
        step("snz_pre",    24'h072959, 1'b0, 1'b0, 4'b0000);
        step("snz_ring",   24'h073000, 1'b0, 1'b0, 4'b1110);
        step("snz_enter",  24'h073000, 1'b1, 1'b0, 4'b0010);
        step("snz_nostb",  24'h073000, 1'b0, 1'b0, 4'b0010);
        step("snz_s1",     24'h073001, 1'b0, 1'b0, 4'b0010);
        step("snz_s2",     24'h073002, 1'b0, 1'b0, 4'b0010);
        step("snz_expire", 24'h073003, 1'b0, 1'b0, 4'b1110);
        step("snz_stop",   24'h073003, 1'b0, 1'b1, 4'b0000);
        step("snz_stoprl", 24'h073003, 1'b0, 1'b0, 4'b0000);

        // stop and snooze rising together: stop wins
        step("both_pre",   24'h072959, 1'b0, 1'b0, 4'b0000);
        step("both_ring",  24'h073000, 1'b0, 1'b0, 4'b1110);
        step("both_edge",  24'h073000, 1'b1, 1'b1, 4'b0000);
        step("both_rel",   24'h073000, 1'b0, 1'b0, 4'b0000);

        // snooze held high: only one SNOOZE entry
        step("hold_pre",   24'h072959, 1'b0, 1'b0, 4'b0000);
        step("hold_ring",  24'h073000, 1'b0, 1'b0, 4'b1110);
        step("hold_snz",   24'h073000, 1'b1, 1'b0, 4'b0010);
        step("hold_s1",    24'h073001, 1'b1, 1'b0, 4'b0010);
        step("hold_s2",    24'h073002, 1'b1, 1'b0, 4'b0010);
        step("hold_rering",24'h073003, 1'b1, 1'b0, 4'b1110);
        step("hold_b1",    24'h073003, 1'b1, 1'b0, 4'b1110);
        step("hold_b2",    24'h073003, 1'b1, 1'b0, 4'b0110);
        step("hold_b3",    24'h073003, 1'b1, 1'b0, 4'b0110);
        step("hold_b4",    24'h073003, 1'b1, 1'b0, 4'b1110);
        step("hold_stop",  24'h073003, 1'b1, 1'b1, 4'b0000);
        step("hold_rel",   24'h073003, 1'b0, 1'b0, 4'b0000);

        // disarmed at the match second
        bus.alarm_en = 1'b0;
        step("dis_pre",    24'h072959, 1'b0, 1'b0, 4'b0000);
        step("dis_match",  24'h073000, 1'b0, 1'b0, 4'b0000);
        bus.alarm_en = 1'b1;
        step("dis_rearm",  24'h073000, 1'b0, 1'b0, 4'b0000);

        // asynchronous reset in SNOOZE, then alarm must sit at 00:00
        step("rst_pre",    24'h072959, 1'b0, 1'b0, 4'b0000);
        step("rst_ring",   24'h073000, 1'b0, 1'b0, 4'b1110);
        step("rst_snz",    24'h073000, 1'b1, 1'b0, 4'b0010);
        step("rst_snzrel", 24'h073000, 1'b0, 1'b0, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        push_exp("rst_async", 4'b0000);
        check_out();
        rst = 1'b0;
        step("zero_pre",   24'h235959, 1'b0, 1'b0, 4'b0000);
        step("zero_match", 24'h000000, 1'b0, 1'b0, 4'b1110);
        step("zero_stop",  24'h000000, 1'b0, 1'b1, 4'b0000);
        step("zero_rel",   24'h000000, 1'b0, 1'b0, 4'b0000);

        // 23:59 is the highest valid load; alarm_en=0 ends RINGING
        bus.set_alarm = 1'b1;
        drive_adj(16'h2359);
        step("load_2359",  24'h000000, 1'b0, 1'b0, 4'b0000);
        bus.set_alarm = 1'b0;
        step("max_pre",    24'h235859, 1'b0, 1'b0, 4'b0000);
        step("max_match",  24'h235900, 1'b0, 1'b0, 4'b1110);
        bus.alarm_en = 1'b0;
        step("en_off",     24'h235900, 1'b0, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
